// File: rtl/cx_dma_pkg.sv
// Shared types and helpers for the CX DMA transmit path.
package cx_dma_pkg;

  localparam int CX_DATA_WIDTH = 32;
  localparam int CX_ID_WIDTH   = 8;

  typedef struct packed {
    logic [CX_DATA_WIDTH-1:0] data;
    logic [CX_ID_WIDTH-1:0]   id;
  } gen_word_t;

  // Why the head word leaves the FIFO this cycle, in priority order.
  typedef enum logic [1:0] {
    LOAD_NONE,
    LOAD_CAP,
    LOAD_NEXT,
    LOAD_TIMEOUT
  } load_reason_e;

  function automatic int strb_width(input int data_width);
    return (data_width + 7) / 8;
  endfunction

endpackage

// File: rtl/cx_gen_to_stream_if.sv
// Word-in (gen) and AXI-stream-style (stream) interfaces used by the packetizer.
interface gen_interface
  import cx_dma_pkg::*;
#(
  parameter int DATA_WIDTH = CX_DATA_WIDTH,
  parameter int ID_WIDTH   = CX_ID_WIDTH
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [ID_WIDTH-1:0]   id;

  modport master (output valid, output data, output id, input  ready);
  modport slave  (input  valid, input  data, input  id, output ready);
endinterface

interface stream_interface
  import cx_dma_pkg::*;
#(
  parameter int DATA_WIDTH = CX_DATA_WIDTH,
  parameter int ID_WIDTH   = CX_ID_WIDTH
);
  logic                              tvalid;
  logic                              tready;
  logic                              tlast;
  logic [DATA_WIDTH-1:0]             tdata;
  logic [strb_width(DATA_WIDTH)-1:0] tstrb;
  logic [ID_WIDTH-1:0]               tid;

  modport master (output tvalid, output tlast, output tdata, output tstrb, output tid,
                  input  tready);
  modport slave  (input  tvalid, input  tlast, input  tdata, input  tstrb, input  tid,
                  output tready);
endinterface

// File: rtl/cx_gen_fifo.sv
// Synchronous FIFO exposing the head entry, the low bits of the entry behind it,
// and the fill count.
module cx_gen_fifo #(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 40,
  parameter int SECOND_W = 8,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_push,
  input  logic [WIDTH-1:0]    i_wdata,
  input  logic                i_pop,
  output logic [WIDTH-1:0]    o_head,
  output logic [SECOND_W-1:0] o_second,
  output logic [CNT_W-1:0]    o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_rd_next;

  // NOTE: storage has no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: every register is written with <= so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_rd_next = r_rd_ptr + 1'b1;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_second  = r_mem[w_rd_next][SECOND_W-1:0];
  assign o_count   = r_count;

endmodule

// File: rtl/cx_gen_to_stream.sv
// Packetizer: buffers gen words and emits stream beats, closing a packet on id
// change, on reaching PKT_LEN beats, or when a lone head word idles for TIMEOUT cycles.
module cx_gen_to_stream
  import cx_dma_pkg::*;
#(
  parameter int DATA_WIDTH = CX_DATA_WIDTH,
  parameter int ID_WIDTH   = CX_ID_WIDTH,
  parameter int PKT_LEN    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic            clk,
  input  logic            rst,
  gen_interface.slave     in,
  stream_interface.master out
);

  localparam int WORD_W = DATA_WIDTH + ID_WIDTH;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BEAT_W = $clog2(PKT_LEN);
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0]  CNT_TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [WORD_W-1:0]     w_head;
  logic [ID_WIDTH-1:0]   w_second_id;
  logic [CNT_W-1:0]      w_count;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [ID_WIDTH-1:0]   w_head_id;
  logic                  w_push;
  logic                  w_reg_free;
  logic                  w_load;
  logic                  w_next_last;
  load_reason_e          w_reason;

  logic                  r_tvalid;
  logic                  r_tlast;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [ID_WIDTH-1:0]   r_tid;
  logic [BEAT_W-1:0]     r_beat_cnt;
  logic [IDLE_W-1:0]     r_idle_cnt;

  assign in.ready = (w_count != CNT_FULL);
  assign w_push   = in.valid && in.ready;

  cx_gen_fifo #(
    .DEPTH    (FIFO_DEPTH),
    .WIDTH    (WORD_W),
    .SECOND_W (ID_WIDTH),
    .CNT_W    (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_wdata  ({in.data, in.id}),
    .i_pop    (w_load),
    .o_head   (w_head),
    .o_second (w_second_id),
    .o_count  (w_count)
  );

  assign w_head_data = w_head[WORD_W-1 -: DATA_WIDTH];
  assign w_head_id   = w_head[ID_WIDTH-1:0];
  assign w_reg_free  = !r_tvalid || out.tready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_reason = LOAD_NONE;
    if (w_count != CNT_ZERO) begin
      if (r_beat_cnt == BEAT_LAST)     w_reason = LOAD_CAP;
      else if (w_count >= CNT_TWO)     w_reason = LOAD_NEXT;
      else if (r_idle_cnt == IDLE_LAST) w_reason = LOAD_TIMEOUT;
    end
  end

  assign w_load      = w_reg_free && (w_reason != LOAD_NONE);
  assign w_next_last = (w_reason == LOAD_NEXT) ? (w_second_id != w_head_id) : 1'b1;

  // The beat is only replaced on a load, so a held beat never changes under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_tid    <= '0;
    end else if (w_load) begin
      r_tvalid <= 1'b1;
      r_tlast  <= w_next_last;
      r_tdata  <= w_head_data;
      r_tid    <= w_head_id;
    end else if (out.tready) begin
      r_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (w_load) begin
      r_beat_cnt <= w_next_last ? '0 : r_beat_cnt + 1'b1;
    end
  end

  // Saturating at IDLE_LAST keeps a timed-out head ready to load once the register frees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if (w_push || w_load || (w_count == CNT_ZERO)) begin
      r_idle_cnt <= '0;
    end else if ((w_count == CNT_ONE) && (r_idle_cnt != IDLE_LAST)) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign out.tvalid = r_tvalid;
  assign out.tlast  = r_tlast;
  assign out.tdata  = r_tdata;
  assign out.tid    = r_tid;
  assign out.tstrb  = '1;

endmodule
